// File: rtl/fft_r2_stage_sequencer_if.sv
// Interface bundle between the FFT stage sequencer and its datapath/RAM.
// The sequencer connects through `master`; the datapath side uses `slave`.
interface fft_r2_stage_sequencer_if #(
    parameter int N_LOG2 = 4
) ();
    // Run control
    logic              start;
    logic              modify_cfg;
    logic              hold;
    logic              busy;
    logic              done;
    logic [N_LOG2-1:0] stage;

    // Read side: RAM data pair and twiddle ROM
    logic              rd_en;
    logic [N_LOG2-1:0] rd_addr1;
    logic [N_LOG2-1:0] rd_addr2;
    logic [N_LOG2-2:0] tw_addr;

    // Butterfly control
    logic              bf_en;
    logic              bf_en_modify;

    // Write-back side
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr1;
    logic [N_LOG2-1:0] wr_addr2;

    modport master (
        input  start, modify_cfg, hold,
        output busy, done, stage,
        output rd_en, rd_addr1, rd_addr2, tw_addr,
        output bf_en, bf_en_modify,
        output wr_en, wr_addr1, wr_addr2
    );

    modport slave (
        output start, modify_cfg, hold,
        input  busy, done, stage,
        input  rd_en, rd_addr1, rd_addr2, tw_addr,
        input  bf_en, bf_en_modify,
        input  wr_en, wr_addr1, wr_addr2
    );
endinterface

// File: rtl/fft_r2_stage_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT. Walks all log2(N)
// stages, issuing one butterfly read per cycle, then aligns the butterfly
// enable and the write-back with the returning data through delay lines.
// rst_n is an active-high synchronous reset; the name is historical.
module fft_r2_stage_sequencer #(
    parameter int N_LOG2     = 4,
    parameter int MEM_RD_LAT = 1,
    parameter int BF_LAT     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fft_r2_stage_sequencer_if.master bus
);
    localparam int PIPE_LEN = MEM_RD_LAT + BF_LAT;
    localparam int CNT_W    = (PIPE_LEN > 1) ? $clog2(PIPE_LEN) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [N_LOG2-1:0] STAGE_ONE  = N_LOG2'(1);
    localparam logic [N_LOG2-1:0] LAST_STAGE = N_LOG2'(N_LOG2 - 1);
    localparam logic [N_LOG2-2:0] B_ONE      = (N_LOG2 - 1)'(1);
    localparam logic [N_LOG2-2:0] B_LAST     = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(PIPE_LEN - 1);

    logic [1:0]        state;
    logic [N_LOG2-1:0] stage_q;
    logic [N_LOG2-2:0] b_q;
    logic              mod_q;
    logic [CNT_W-1:0]  drain_cnt;

    logic              rd_en;
    logic [N_LOG2-1:0] b_ext;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] addr1;
    logic [N_LOG2-1:0] addr2;
    logic [N_LOG2-2:0] tw;

    // Read-to-write delay line; entry i holds what was issued i+1 cycles ago.
    logic              pipe_en  [PIPE_LEN];
    logic              pipe_mod [MEM_RD_LAT];
    logic [N_LOG2-1:0] pipe_a1  [PIPE_LEN];
    logic [N_LOG2-1:0] pipe_a2  [PIPE_LEN];

    // Stage/butterfly walk: IDLE -> (ISSUE -> DRAIN) x N_LOG2 -> FINISH.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= S_IDLE;
            stage_q   <= '0;
            b_q       <= '0;
            mod_q     <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mod_q   <= bus.modify_cfg;
                        stage_q <= '0;
                        b_q     <= '0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!bus.hold) begin
                        if (b_q == B_LAST) begin
                            b_q       <= '0;
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end else begin
                            b_q <= b_q + B_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    // Drain length covers read + butterfly latency, so the next
                    // stage never reads a location before its write-back.
                    if (drain_cnt == DRAIN_LAST) begin
                        drain_cnt <= '0;
                        if (stage_q == LAST_STAGE) begin
                            state <= S_FINISH;
                        end else begin
                            stage_q <= stage_q + STAGE_ONE;
                            state   <= S_ISSUE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + CNT_ONE;
                    end
                end
                S_FINISH: begin
                    stage_q <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Butterfly address generation for stage s, butterfly b.
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        b_ext = {1'b0, b_q};
        pos   = b_ext & ((STAGE_ONE << stage_q) - STAGE_ONE);
        addr1 = ((b_ext >> stage_q) << (stage_q + STAGE_ONE)) | pos;
        addr2 = addr1 + (STAGE_ONE << stage_q);
        tw    = (N_LOG2 - 1)'(pos << (LAST_STAGE - stage_q));
    end

    assign rd_en = (state == S_ISSUE) && !bus.hold;

    // Shift issued reads toward the butterfly and write-back ports.
    // NOTE: the delay line is reset (unlike a RAM) so a reset mid-run drops in-flight writes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < PIPE_LEN; i++) begin
                pipe_en[i] <= 1'b0;
                pipe_a1[i] <= '0;
                pipe_a2[i] <= '0;
            end
            for (int i = 0; i < MEM_RD_LAT; i++) begin
                pipe_mod[i] <= 1'b0;
            end
        end else begin
            pipe_en[0]  <= rd_en;
            pipe_a1[0]  <= rd_en ? addr1 : '0;
            pipe_a2[0]  <= rd_en ? addr2 : '0;
            pipe_mod[0] <= rd_en && mod_q && (stage_q == LAST_STAGE);
            for (int i = 1; i < PIPE_LEN; i++) begin
                pipe_en[i] <= pipe_en[i-1];
                pipe_a1[i] <= pipe_a1[i-1];
                pipe_a2[i] <= pipe_a2[i-1];
            end
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                pipe_mod[i] <= pipe_mod[i-1];
            end
        end
    end

    assign bus.busy         = (state == S_ISSUE) || (state == S_DRAIN);
    assign bus.done         = (state == S_FINISH);
    assign bus.stage        = stage_q;
    assign bus.rd_en        = rd_en;
    assign bus.rd_addr1     = rd_en ? addr1 : '0;
    assign bus.rd_addr2     = rd_en ? addr2 : '0;
    assign bus.tw_addr      = rd_en ? tw : '0;
    assign bus.bf_en        = pipe_en[MEM_RD_LAT-1];
    assign bus.bf_en_modify = pipe_mod[MEM_RD_LAT-1];
    assign bus.wr_en        = pipe_en[PIPE_LEN-1];
    assign bus.wr_addr1     = pipe_a1[PIPE_LEN-1];
    assign bus.wr_addr2     = pipe_a2[PIPE_LEN-1];
endmodule
